// File: rtl/cxd2545_edge_timer.sv
// Multi-channel edge timer: shared prescaler tick, toggle clock output and
// per-channel high-width / rise-to-rise period measurement with ack handshake.
module cxd2545_edge_timer #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 31,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned TOG_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DIV_W-1:0]          div,
    input  logic [TOG_W-1:0]          toggle_cnt,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       trigger,
    input  logic [CHANNELS-1:0]       ack,
    output logic                      tick,
    output logic                      toggle_clk,
    output logic [CHANNELS-1:0]       meas_valid,
    output logic [CHANNELS-1:0]       meas_ovf,
    output logic [CHANNELS*CNT_W-1:0] meas_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [DIV_W-1:0]    pre_cnt;
    logic [TOG_W-1:0]    tog_cnt;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] rise_c;
    logic [CHANNELS-1:0] fall_c;

    state_t              state_q    [CHANNELS];
    state_t              state_d    [CHANNELS];
    logic [CNT_W-1:0]    run_cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    run_cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] sat_q;
    logic [CHANNELS-1:0] sat_d;
    logic [CHANNELS-1:0] cur_mode_q;
    logic [CHANNELS-1:0] cur_mode_d;
    logic [CHANNELS-1:0] latch_c;

    // Prescaler: registered one-clk tick every div+1 enabled clocks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (!enable) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (pre_cnt >= div) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

    // Toggle output: flips every toggle_cnt+1 ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_cnt    <= '0;
            toggle_clk <= 1'b0;
        end else if (tick) begin
            if (tog_cnt >= toggle_cnt) begin
                tog_cnt    <= '0;
                toggle_clk <= ~toggle_clk;
            end else begin
                tog_cnt <= tog_cnt + TOG_W'(1);
            end
        end
    end

    // Trigger synchroniser every clk; edge reference sampled on tick only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= trigger;
            sync2 <= sync1;
            if (tick) begin
                prev <= sync2;
            end
        end
    end

    assign rise_c = sync2 & ~prev;
    assign fall_c = ~sync2 & prev;

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]   <= ST_IDLE;
                run_cnt_q[i] <= '0;
            end
            sat_q      <= '0;
            cur_mode_q <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i]   <= state_d[i];
                run_cnt_q[i] <= run_cnt_d[i];
            end
            sat_q      <= sat_d;
            cur_mode_q <= cur_mode_d;
        end
    end

    // Channel next-state: start, terminate/latch, or count with saturation
    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        sat_d      = sat_q;
        cur_mode_d = cur_mode_q;
        latch_c    = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (tick) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (rise_c[i]) begin
                            state_d[i]    = ST_RUN;
                            run_cnt_d[i]  = CNT_W'(1);
                            sat_d[i]      = 1'b0;
                            cur_mode_d[i] = mode[i];
                        end
                    end
                    ST_RUN: begin
                        if (!cur_mode_q[i] && fall_c[i]) begin
                            latch_c[i] = 1'b1;
                            state_d[i] = ST_IDLE;
                        end else if (cur_mode_q[i] && rise_c[i]) begin
                            latch_c[i]    = 1'b1;
                            run_cnt_d[i]  = CNT_W'(1);
                            sat_d[i]      = 1'b0;
                            cur_mode_d[i] = mode[i];
                        end else if (run_cnt_q[i] == CNT_MAX) begin
                            sat_d[i] = 1'b1;
                        end else begin
                            run_cnt_d[i] = run_cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Result registers: a latch beats a coincident ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid <= '0;
            meas_ovf   <= '0;
            meas_count <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (latch_c[i]) begin
                    meas_count[i*CNT_W +: CNT_W] <= run_cnt_q[i];
                    meas_ovf[i]                  <= sat_q[i];
                    meas_valid[i]                <= 1'b1;
                end else if (ack[i]) begin
                    meas_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cxd2545_edge_timer.sv
// Bench for cxd2545_edge_timer: directed scenarios plus randomized traffic
// checked against a timestamp-based reference model (wide and narrow counter).
module tb_cxd2545_edge_timer;

    localparam int WA   = 31;
    localparam int WB   = 4;
    localparam longint MAXA = (longint'(1) << WA) - 1;
    localparam longint MAXB = (longint'(1) << WB) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] div;
    logic [15:0] toggle_cnt;
    logic [1:0]  mode;
    logic [1:0]  trigger;
    logic [1:0]  ack;

    logic        tick_a, tick_b, toggle_a, toggle_b;
    logic [1:0]  valid_a, valid_b, ovf_a, ovf_b;
    logic [2*WA-1:0] count_a;
    logic [2*WB-1:0] count_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cxd2545_edge_timer #(.CHANNELS(2), .CNT_W(WA), .DIV_W(16), .TOG_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div(div), .toggle_cnt(toggle_cnt),
        .mode(mode), .trigger(trigger), .ack(ack), .tick(tick_a), .toggle_clk(toggle_a),
        .meas_valid(valid_a), .meas_ovf(ovf_a), .meas_count(count_a));

    cxd2545_edge_timer #(.CHANNELS(2), .CNT_W(WB), .DIV_W(16), .TOG_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .div(div), .toggle_cnt(toggle_cnt),
        .mode(mode), .trigger(trigger), .ack(ack), .tick(tick_b), .toggle_clk(toggle_b),
        .meas_valid(valid_b), .meas_ovf(ovf_b), .meas_count(count_b));

    // Reference model: measurements are tick-index differences, clipped to the counter range
    logic       e_tick, e_tog;
    logic [1:0] e_valid, e_ovf_a, e_ovf_b;
    longint     e_cnt_a [2];
    longint     e_cnt_b [2];
    logic [1:0] m_s1, m_s2, m_seen, m_running, m_pmode;
    longint     m_start [2];
    longint     m_tidx, m_run_k, m_togticks;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_tick = 0; e_tog = 0; e_valid = 0; e_ovf_a = 0; e_ovf_b = 0;
            m_s1 = 0; m_s2 = 0; m_seen = 0; m_running = 0; m_pmode = 0;
            m_tidx = 0; m_run_k = 0; m_togticks = 0;
            for (int c = 0; c < 2; c++) begin
                e_cnt_a[c] = 0; e_cnt_b[c] = 0; m_start[c] = 0;
            end
        end else begin
            logic [1:0] lat;
            lat = 0;
            if (e_tick) begin
                if (m_togticks >= longint'(toggle_cnt)) begin
                    e_tog = ~e_tog;
                    m_togticks = 0;
                end else begin
                    m_togticks++;
                end
                for (int c = 0; c < 2; c++) begin
                    logic v, r, f;
                    longint n;
                    v = m_s2[c];
                    r = v & ~m_seen[c];
                    f = ~v & m_seen[c];
                    m_seen[c] = v;
                    if (m_running[c]) begin
                        if ((!m_pmode[c] && f) || (m_pmode[c] && r)) begin
                            n = m_tidx - m_start[c];
                            e_cnt_a[c] = (n > MAXA) ? MAXA : n;
                            e_ovf_a[c] = (n > MAXA);
                            e_cnt_b[c] = (n > MAXB) ? MAXB : n;
                            e_ovf_b[c] = (n > MAXB);
                            lat[c] = 1;
                            if (m_pmode[c]) begin
                                m_start[c] = m_tidx;
                                m_pmode[c] = mode[c];
                            end else begin
                                m_running[c] = 0;
                            end
                        end
                    end else if (r) begin
                        m_running[c] = 1;
                        m_start[c]   = m_tidx;
                        m_pmode[c]   = mode[c];
                    end
                end
                m_tidx++;
            end
            for (int c = 0; c < 2; c++) begin
                if (lat[c]) e_valid[c] = 1;
                else if (ack[c]) e_valid[c] = 0;
            end
            m_s2 = m_s1;
            m_s1 = trigger;
            if (enable) begin
                m_run_k++;
                e_tick = ((m_run_k % (longint'(div) + 1)) == 0);
            end else begin
                m_run_k = 0;
                e_tick = 0;
            end
        end
    end

    task automatic wait_ticks(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 100 * n + 100) begin
            @(negedge clk);
            cyc++;
            if (tick_a === 1'b1) got++;
        end
        n_cmp++;
        if (got < n) begin
            n_bad++;
            $display("FAIL wait_ticks: saw %0d ticks, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; div = 16'd4; toggle_cnt = 16'd2;
        mode = 0; trigger = 0; ack = 0;
        #1;
        n_cmp++;
        if ({tick_a, toggle_a, valid_a, ovf_a, count_a} !== '0 ||
            {tick_b, toggle_b, valid_b, ovf_b, count_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: a=%h b=%h required all zero",
                     {tick_a, toggle_a, valid_a, ovf_a, count_a}, {tick_b, toggle_b, valid_b, ovf_b, count_b});
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_tick_toggle();
        int gap, cnt, bad;
        logic prv, hold;
        enable = 1;
        wait_ticks(1);
        for (int r = 0; r < 3; r++) begin
            gap = 0;
            do begin @(negedge clk); gap++; end while (tick_a !== 1'b1 && gap < 50);
            n_cmp++;
            if (gap !== 5) begin n_bad++; $display("FAIL tick_period: got %0d clk, required 5", gap); end
        end
        prv = toggle_a; cnt = 0;
        while (toggle_a === prv && cnt < 100) begin @(negedge clk); cnt++; end
        prv = toggle_a; cnt = 0;
        while (toggle_a === prv && cnt < 100) begin @(negedge clk); cnt++; end
        n_cmp++;
        if (cnt !== 15) begin n_bad++; $display("FAIL toggle_half_period: got %0d clk, required 15", cnt); end
        wait_ticks(1);
        @(negedge clk);
        enable = 0;
        hold = toggle_a;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick_a !== 1'b0 || toggle_a !== hold) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL enable_freeze: %0d cycles moved, required 0", bad); end
        enable = 1;
    endtask

    task automatic test_high_width();
        mode[0] = 0;
        wait_ticks(1);
        trigger[0] = 1;
        wait_ticks(10);
        trigger[0] = 0;
        wait_ticks(1);
        @(negedge clk);
        n_cmp++;
        if (valid_a[0] !== 1'b1 || ovf_a[0] !== 1'b0 || count_a[0 +: WA] !== WA'(10)) begin
            n_bad++;
            $display("FAIL high_width: valid=%b ovf=%b count=%0d, required 1 0 10", valid_a[0], ovf_a[0], count_a[0 +: WA]);
        end
        n_cmp++;
        if (ovf_b[0] !== 1'b0 || count_b[0 +: WB] !== WB'(10)) begin
            n_bad++;
            $display("FAIL high_width_narrow: ovf=%b count=%0d, required 0 10", ovf_b[0], count_b[0 +: WB]);
        end
        ack[0] = 1;
        @(negedge clk);
        ack[0] = 0;
        n_cmp++;
        if (valid_a[0] !== 1'b0 || count_a[0 +: WA] !== WA'(10)) begin
            n_bad++;
            $display("FAIL ack_clear: valid=%b count=%0d, required 0 10", valid_a[0], count_a[0 +: WA]);
        end
    endtask

    task automatic test_period();
        mode[1] = 1;
        for (int r = 0; r < 4; r++) begin
            if (r == 3) mode[1] = 0;
            trigger[1] = 1;
            wait_ticks(1);
            @(negedge clk);
            if (r > 0) begin
                n_cmp++;
                if (valid_a[1] !== 1'b1 || count_a[WA +: WA] !== WA'(7) || count_b[WB +: WB] !== WB'(7)) begin
                    n_bad++;
                    $display("FAIL period_%0d: valid=%b count=%0d/%0d, required 1 7/7", r, valid_a[1], count_a[WA +: WA], count_b[WB +: WB]);
                end
            end
            ack[1] = 1;
            @(negedge clk);
            ack[1] = 0;
            n_cmp++;
            if (valid_a[1] !== 1'b0) begin n_bad++; $display("FAIL period_ack_%0d: valid=%b, required 0", r, valid_a[1]); end
            wait_ticks(2);
            trigger[1] = 0;
            wait_ticks(4);
        end
        n_cmp++;
        if (valid_a[1] !== 1'b1 || count_a[WA +: WA] !== WA'(3)) begin
            n_bad++;
            $display("FAIL mode_switch_width: valid=%b count=%0d, required 1 3", valid_a[1], count_a[WA +: WA]);
        end
    endtask

    task automatic test_saturation();
        mode[0] = 0;
        wait_ticks(1);
        trigger[0] = 1;
        wait_ticks(20);
        trigger[0] = 0;
        wait_ticks(1);
        @(negedge clk);
        n_cmp++;
        if (count_a[0 +: WA] !== WA'(20) || ovf_a[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL wide_no_sat: count=%0d ovf=%b, required 20 0", count_a[0 +: WA], ovf_a[0]);
        end
        n_cmp++;
        if (count_b[0 +: WB] !== WB'(15) || ovf_b[0] !== 1'b1 || valid_b[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL narrow_sat: count=%0d ovf=%b valid=%b, required 15 1 1", count_b[0 +: WB], ovf_b[0], valid_b[0]);
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'b00;
        wait_ticks(1);
        trigger[0] = 1;
        wait_ticks(4);
        trigger[0] = 0;
        wait_ticks(1);
        ack[0] = 1;
        @(negedge clk);
        ack[0] = 0;
        n_cmp++;
        if (valid_a[0] !== 1'b1 || count_a[0 +: WA] !== WA'(4)) begin
            n_bad++;
            $display("FAIL ack_vs_latch: valid=%b count=%0d, required 1 4", valid_a[0], count_a[0 +: WA]);
        end
        wait_ticks(1);
        trigger = 2'b11;
        wait_ticks(6);
        trigger = 2'b00;
        wait_ticks(1);
        @(negedge clk);
        n_cmp++;
        if (valid_a !== 2'b11 || count_a[0 +: WA] !== WA'(6) || count_a[WA +: WA] !== WA'(6)) begin
            n_bad++;
            $display("FAIL simultaneous: valid=%b count0=%0d count1=%0d, required 11 6 6", valid_a, count_a[0 +: WA], count_a[WA +: WA]);
        end
    endtask

    task automatic test_reset_mid_run();
        mode[0] = 0;
        wait_ticks(1);
        trigger[0] = 1;
        wait_ticks(3);
        @(negedge clk);
        rst_n = 0;
        #1;
        n_cmp++;
        if ({tick_a, toggle_a, valid_a, ovf_a, count_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run: outputs=%h, required 0", {tick_a, toggle_a, valid_a, ovf_a, count_a});
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        wait_ticks(1);
        n_cmp++;
        if (valid_a[0] !== 1'b0) begin n_bad++; $display("FAIL no_latch_after_reset: valid=%b, required 0", valid_a[0]); end
        wait_ticks(4);
        trigger[0] = 0;
        wait_ticks(1);
        @(negedge clk);
        n_cmp++;
        if (valid_a[0] !== 1'b1 || count_a[0 +: WA] !== WA'(5)) begin
            n_bad++;
            $display("FAIL restart_after_reset: valid=%b count=%0d, required 1 5", valid_a[0], count_a[0 +: WA]);
        end
    endtask

    task automatic test_random();
        for (int cfg = 0; cfg < 3; cfg++) begin
            @(negedge clk);
            rst_n = 0; trigger = 0; ack = 0; mode = 2'($urandom);
            div = 16'($urandom_range(0, 3));
            toggle_cnt = 16'($urandom_range(0, 3));
            enable = 1;
            repeat (2) @(negedge clk);
            rst_n = 1;
            for (int cy = 0; cy < 2500; cy++) begin
                @(negedge clk);
                n_cmp++;
                if (tick_a !== e_tick || toggle_a !== e_tog || tick_b !== e_tick || toggle_b !== e_tog) begin
                    n_bad++;
                    $display("FAIL rand_tick cy=%0d: tick=%b/%b toggle=%b/%b, required %b %b", cy, tick_a, tick_b, toggle_a, toggle_b, e_tick, e_tog);
                end
                for (int c = 0; c < 2; c++) begin
                    n_cmp++;
                    if (valid_a[c] !== e_valid[c] || ovf_a[c] !== e_ovf_a[c] || count_a[c*WA +: WA] !== WA'(e_cnt_a[c]) ||
                        valid_b[c] !== e_valid[c] || ovf_b[c] !== e_ovf_b[c] || count_b[c*WB +: WB] !== WB'(e_cnt_b[c])) begin
                        n_bad++;
                        $display("FAIL rand_ch%0d cy=%0d: v=%b/%b o=%b/%b c=%0d/%0d, required v=%b o=%b/%b c=%0d/%0d", c, cy,
                                 valid_a[c], valid_b[c], ovf_a[c], ovf_b[c], count_a[c*WA +: WA], count_b[c*WB +: WB],
                                 e_valid[c], e_ovf_a[c], e_ovf_b[c], e_cnt_a[c], e_cnt_b[c]);
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if ($urandom_range(0, 9) == 0) trigger[c] = ~trigger[c];
                    ack[c] = ($urandom_range(0, 11) == 0);
                    if ($urandom_range(0, 39) == 0) mode[c] = ~mode[c];
                end
                enable = ($urandom_range(0, 29) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_toggle();
        test_high_width();
        test_period();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
